nerv_dmem_arbiter: RTL
======================

// Module: nerv_dmem_arbiter
// PURPOSE
//   Shares one single-port data SRAM (1-cycle read latency, byte write strobes) between the NERV CPU
//   data port and one auxiliary master (debug/loader/DMA). Sits between cpu dmem_* and the SoC RAM.
//   CPU has priority; a starvation counter forces an AUX slot after MAX_WAIT blocked cycles.
//   CPU loss of arbitration is signalled through the CPU's combinational stall input.
// PARAMETERS
//   AW        32  byte-address width, all ports
//   MAX_WAIT  4   consecutive blocked AUX cycles before forced AUX grant; legal range 1..255
// PORTS
//   clock       in   1   sole clock, rising edge
//   resetn      in   1   synchronous, active-low reset
//   cpu_valid   in   1   CPU data access request (dmem_valid)
//   cpu_addr    in   AW  CPU byte address
//   cpu_wstrb   in   4   CPU byte write strobes; 0 = read
//   cpu_wdata   in   32  CPU write data
//   cpu_rdata   out  32  read data, valid cycle after CPU grant
//   cpu_stall   out  1   combinational; 1 = CPU request not granted this cycle, CPU holds request
//   aux_valid   in   1   AUX request; must hold addr/wstrb/wdata stable until aux_ready
//   aux_ready   out  1   combinational grant; transfer when aux_valid && aux_ready
//   aux_addr    in   AW  AUX byte address
//   aux_wstrb   in   4   AUX write strobes; 0 = read
//   aux_wdata   in   32  AUX write data
//   aux_rvalid  out  1   1-cycle pulse, cycle after AUX read grant
//   aux_rdata   out  32  AUX read data, valid with aux_rvalid
//   mem_en      out  1   SRAM access enable
//   mem_addr    out  AW  SRAM byte address (word index = mem_addr[AW-1:2])
//   mem_wstrb   out  4   SRAM byte write strobes
//   mem_wdata   out  32  SRAM write data
//   mem_rdata   in   32  SRAM read data, 1 cycle after mem_en
// BEHAVIOUR
//   - Reset: state=S_CPU_PRI, starve_cnt=0, last_gnt=GNT_NONE, aux_rvalid=0, cpu_rdata=0, aux_rdata=0.
//     cpu_stall/aux_ready/mem_* are combinational; during reset they evaluate with state=S_CPU_PRI.
//   - FSM: S_CPU_PRI: grant CPU if cpu_valid, else AUX if aux_valid, else none.
//     S_AUX_FORCE: grant AUX if aux_valid, else CPU if cpu_valid.
//   - starve_cnt (8b): +1 each cycle aux_valid && !aux_ready, cleared on AUX grant or !aux_valid.
//     S_CPU_PRI -> S_AUX_FORCE when starve_cnt reaches MAX_WAIT-1 and AUX blocked again this cycle.
//     S_AUX_FORCE -> S_CPU_PRI after one AUX grant, or when aux_valid drops (no grant).
//   - Simultaneous cpu_valid && aux_valid with MAX_WAIT=4: 4 CPU grants, 1 AUX grant, repeat.
//   - Grant drives mem_* from winner's request; mem_en=0 and mem_wstrb=0 when no grant.
//   - cpu_stall = cpu_valid && grant!=GNT_CPU; aux_ready = (grant==GNT_AUX).
//   - last_gnt registers the grant; cycle after a grant, mem_rdata is steered:
//     GNT_CPU -> cpu_rdata (registered hold, stays until next CPU grant);
//     GNT_AUX -> aux_rdata, aux_rvalid=1 only if that AUX access was a read (wstrb==0).
//   - Writes give no AUX response; ordering between masters is grant order; no address checks.
//   - Reset mid-access: pending aux_rvalid suppressed, counters cleared, no partial write beyond
//     the cycle already presented to the SRAM.
// CONFIGURATION
//   NERV_DMEM_ARB_STATS_EN defined: adds ports stat_cpu_stall[31:0] (cycles cpu_stall=1) and
//     stat_aux_force[31:0] (entries into S_AUX_FORCE); both saturate at 32'hFFFF_FFFF, cleared by reset.
//   Not defined: stat ports absent, no counter logic; arbitration identical.
// STRUCTURE
//   Package nerv_dmem_arb_pkg: typedef enum gnt_t {GNT_NONE, GNT_CPU, GNT_AUX};
//     typedef enum arb_state_t {S_CPU_PRI, S_AUX_FORCE}; localparam STARVE_W = 8.
//   Sub-module nerv_sat_counter #(W): sync active-low clear, inc enable, saturating; used for
//     starve_cnt and both stats counters.
// TESTING
//   1 CPU-only: read word 0x10 after writing 0xDEADBEEF -> cpu_stall=0 always, cpu_rdata=0xDEADBEEF next cycle.
//   2 AUX-only: aux write 0x55AA00FF to 0x20 then read -> aux_ready same cycle, aux_rvalid 1 cycle later, data matches.
//   3 Contention, MAX_WAIT=4, both valid continuously -> grant pattern CPU x4, AUX x1; cpu_stall=1 on AUX cycle.
//   4 Byte strobes: AUX writes wstrb=4'b0010 data 0x0000_AB00 over 0x11223344 -> readback 0x1122AB44.
//   5 aux_valid dropped in S_AUX_FORCE -> return to S_CPU_PRI, starve_cnt=0, no aux_rvalid.
//   6 resetn low during AUX read grant -> aux_rvalid stays 0 next cycle; stats (if enabled) read 0.

Source files
------------

// File: rtl/nerv_dmem_arbiter_pkg.sv
// rtl/nerv_dmem_arbiter_pkg.sv - shared types for the NERV data-memory arbiter
//
// Purpose: grant and FSM state encodings plus the starvation counter width,
//          imported by nerv_dmem_arbiter and its testbench.
// Ports:   none (package).

package nerv_dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_AUX  = 2'd2
  } gnt_t;

  typedef enum logic {
    S_CPU_PRI   = 1'b0,
    S_AUX_FORCE = 1'b1
  } arb_state_t;

  localparam int STARVE_W = 8;

endpackage

// File: rtl/nerv_dmem_arbiter_sat_counter.sv
// rtl/nerv_dmem_arbiter_sat_counter.sv - saturating up-counter with clear
//
// Purpose: W-bit counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock    in  1  rising-edge clock
//   resetn   in  1  synchronous active-low reset
//   i_clr    in  1  synchronous clear, wins over i_inc
//   i_inc    in  1  increment enable
//   o_count  out W  current count

module nerv_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!resetn || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/nerv_dmem_arbiter.sv
// rtl/nerv_dmem_arbiter.sv - CPU/AUX arbiter in front of a single-port data SRAM
//
// Purpose: shares one 1-cycle-latency SRAM between the NERV CPU data port and
//          one auxiliary master. CPU has priority; after MAX_WAIT consecutive
//          blocked AUX cycles the next slot is forced to AUX.
// Optional feature macro: NERV_DMEM_ARB_STATS_EN adds stat_cpu_stall and
//          stat_aux_force saturating counters.
// Ports:
//   clock, resetn                 clock, synchronous active-low reset
//   cpu_valid/addr/wstrb/wdata    CPU request (wstrb 0 = read)
//   cpu_rdata                     CPU read data, cycle after grant, held
//   cpu_stall                     combinational, CPU request not granted
//   aux_valid/addr/wstrb/wdata    AUX request, held until aux_ready
//   aux_ready                     combinational AUX grant
//   aux_rvalid/aux_rdata          AUX read response, cycle after read grant
//   mem_en/addr/wstrb/wdata       SRAM request
//   mem_rdata                     SRAM read data, cycle after mem_en
//   stat_cpu_stall/stat_aux_force (macro only) event counters

module nerv_dmem_arbiter
  import nerv_dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_wstrb,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [AW-1:0] aux_addr,
  input  logic [3:0]    aux_wstrb,
  input  logic [31:0]   aux_wdata,
  output logic          aux_rvalid,
  output logic [31:0]   aux_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef NERV_DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_cpu_stall,
  output logic [31:0]   stat_aux_force
`endif
);

  localparam logic [STARVE_W-1:0] LP_STARVE_LIM = STARVE_W'(MAX_WAIT - 1);

  arb_state_t            r_state;
  arb_state_t            w_state;
  arb_state_t            w_state_nxt;
  gnt_t                  w_gnt;
  gnt_t                  r_last_gnt;
  logic                  r_last_aux_rd;
  logic [31:0]           r_cpu_rdata;
  logic [31:0]           r_aux_rdata;
  logic [STARVE_W-1:0]   w_starve_cnt;
  logic                  w_aux_blocked;
  logic                  w_starve_clr;

  // Combinational outputs must see the priority state while reset is held,
  // even before the first reset edge has loaded r_state.
  assign w_state = resetn ? r_state : S_CPU_PRI;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_CPU_PRI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_gnt         = GNT_NONE;
    w_state_nxt   = w_state;
    w_aux_blocked = 1'b0;
    w_starve_clr  = 1'b0;
    mem_en        = 1'b0;
    mem_addr      = '0;
    mem_wstrb     = 4'b0000;
    mem_wdata     = '0;

    if (w_state == S_AUX_FORCE) begin
      if (aux_valid)      w_gnt = GNT_AUX;
      else if (cpu_valid) w_gnt = GNT_CPU;
    end else begin
      if (cpu_valid)      w_gnt = GNT_CPU;
      else if (aux_valid) w_gnt = GNT_AUX;
    end

    w_aux_blocked = aux_valid && (w_gnt != GNT_AUX);
    w_starve_clr  = !aux_valid || (w_gnt == GNT_AUX);

    case (w_state)
      S_CPU_PRI: begin
        // Counter already shows MAX_WAIT-1 past blocks; this is the MAX_WAIT-th.
        if (w_aux_blocked && (w_starve_cnt == LP_STARVE_LIM)) w_state_nxt = S_AUX_FORCE;
      end
      S_AUX_FORCE: begin
        if ((w_gnt == GNT_AUX) || !aux_valid) w_state_nxt = S_CPU_PRI;
      end
      default: w_state_nxt = S_CPU_PRI;
    endcase

    case (w_gnt)
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wstrb = cpu_wstrb;
        mem_wdata = cpu_wdata;
      end
      GNT_AUX: begin
        mem_en    = 1'b1;
        mem_addr  = aux_addr;
        mem_wstrb = aux_wstrb;
        mem_wdata = aux_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_valid && (w_gnt != GNT_CPU);
  assign aux_ready = (w_gnt == GNT_AUX);

  nerv_sat_counter #(.W(STARVE_W)) u_starve_cnt (
    .clock   (clock),
    .resetn  (resetn),
    .i_clr   (w_starve_clr),
    .i_inc   (w_aux_blocked),
    .o_count (w_starve_cnt)
  );

  // Remember who owned the SRAM last cycle so its read data can be routed
  // back; reset drops any response still in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_last_gnt    <= GNT_NONE;
      r_last_aux_rd <= 1'b0;
      r_cpu_rdata   <= '0;
      r_aux_rdata   <= '0;
    end else begin
      r_last_gnt    <= w_gnt;
      r_last_aux_rd <= (aux_wstrb == 4'b0000);
      if (r_last_gnt == GNT_CPU) r_cpu_rdata <= mem_rdata;
      if (aux_rvalid)            r_aux_rdata <= mem_rdata;
    end
  end

  // Read data is passed straight through in the response cycle and held
  // from the capture register afterwards.
  assign cpu_rdata  = (r_last_gnt == GNT_CPU) ? mem_rdata : r_cpu_rdata;
  assign aux_rvalid = (r_last_gnt == GNT_AUX) && r_last_aux_rd;
  assign aux_rdata  = aux_rvalid ? mem_rdata : r_aux_rdata;

`ifdef NERV_DMEM_ARB_STATS_EN
  logic w_force_entry;
  assign w_force_entry = (w_state == S_CPU_PRI) && (w_state_nxt == S_AUX_FORCE);

  nerv_sat_counter #(.W(32)) u_stat_cpu_stall (
    .clock   (clock),
    .resetn  (resetn),
    .i_clr   (1'b0),
    .i_inc   (cpu_stall),
    .o_count (stat_cpu_stall)
  );

  nerv_sat_counter #(.W(32)) u_stat_aux_force (
    .clock   (clock),
    .resetn  (resetn),
    .i_clr   (1'b0),
    .i_inc   (w_force_entry),
    .o_count (stat_aux_force)
  );
`else
  // Statistics disabled: no counters or stat ports.
`endif

endmodule
